// File: rtl/piece_controller.sv
// Active piece for the gameboard: moves a 4-square horizontal bar, probing occupancy one cell per cycle.
// Optional PIECE_HARD_DROP_EN adds a hard_drop request that falls until blocked.
module piece_controller #(
  parameter int unsigned CELL       = 20,
  parameter int unsigned BOARD_COLS = 20,
  parameter int unsigned BOARD_ROWS = 20,
  parameter int unsigned SPAWN_COL  = 10
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       start,
  input  logic       tick_down,
  input  logic       move_left,
  input  logic       move_right,
`ifdef PIECE_HARD_DROP_EN
  input  logic       hard_drop,
`endif
  input  logic       query_occupied,
  output logic [4:0] query_col,
  output logic [4:0] query_row,
  output logic [9:0] square1x,
  output logic [9:0] square2x,
  output logic [9:0] square3x,
  output logic [9:0] square4x,
  output logic [9:0] square1y,
  output logic [9:0] square2y,
  output logic [9:0] square3y,
  output logic [9:0] square4y,
  output logic       at_bottom,
  output logic       game_over,
  output logic       busy
);

  localparam int unsigned COL_W = 6;
  localparam int unsigned CC_W  = COL_W + 1;
  localparam int unsigned ROW_W = 5;
  localparam int unsigned Q_W   = 5;
  localparam int unsigned PIX_W = 10;
  localparam int unsigned IDX_W = 2;

  typedef enum logic [2:0] {S_IDLE, S_SPAWN, S_WAIT, S_CHECK, S_LAND, S_OVER} state_t;
  typedef enum logic [1:0] {D_DOWN, D_LEFT, D_RIGHT} dir_t;

  state_t             state, nxt_state;
  dir_t               dir, nxt_dir;
  logic [COL_W-1:0]   col, nxt_col, tcol, nxt_tcol;
  logic [ROW_W-1:0]   row, nxt_row, trow, nxt_trow;
  logic [IDX_W-1:0]   idx, nxt_idx;
  logic               blk, nxt_blk;
  logic               hard, nxt_hard;
  logic [Q_W-1:0]     nxt_qcol, nxt_qrow;
  logic               nxt_at_bottom, nxt_game_over, nxt_busy;
  logic [PIX_W-1:0]   sq_x [4];
  logic [PIX_W-1:0]   nxt_sq_x [4];
  logic [PIX_W-1:0]   sq_y, nxt_sq_y;
  logic [CC_W-1:0]    cell_col;
  logic               cell_blk, blk_acc, hd_req;

`ifdef PIECE_HARD_DROP_EN
  assign hd_req = hard_drop;
`else
  assign hd_req = 1'b0;
`endif

  // Left-wall underflow wraps tcol high, so it lands in the >= BOARD_COLS range test.
  assign cell_col = {1'b0, tcol} + CC_W'(idx);
  assign cell_blk = query_occupied || (cell_col >= CC_W'(BOARD_COLS)) || (trow >= ROW_W'(BOARD_ROWS));
  assign blk_acc  = blk | cell_blk;

  assign square1x = sq_x[0];
  assign square2x = sq_x[1];
  assign square3x = sq_x[2];
  assign square4x = sq_x[3];
  assign square1y = sq_y;
  assign square2y = sq_y;
  assign square3y = sq_y;
  assign square4y = sq_y;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= S_IDLE;
      dir       <= D_DOWN;
      col       <= COL_W'(SPAWN_COL);
      row       <= '0;
      tcol      <= COL_W'(SPAWN_COL);
      trow      <= '0;
      idx       <= '0;
      blk       <= 1'b0;
      hard      <= 1'b0;
      query_col <= '0;
      query_row <= '0;
      at_bottom <= 1'b0;
      game_over <= 1'b0;
      busy      <= 1'b0;
      for (int k = 0; k < 4; k++) sq_x[k] <= PIX_W'((SPAWN_COL + 32'(k)) * CELL);
      sq_y      <= '0;
    end else begin
      state     <= nxt_state;
      dir       <= nxt_dir;
      col       <= nxt_col;
      row       <= nxt_row;
      tcol      <= nxt_tcol;
      trow      <= nxt_trow;
      idx       <= nxt_idx;
      blk       <= nxt_blk;
      hard      <= nxt_hard;
      query_col <= nxt_qcol;
      query_row <= nxt_qrow;
      at_bottom <= nxt_at_bottom;
      game_over <= nxt_game_over;
      busy      <= nxt_busy;
      for (int k = 0; k < 4; k++) sq_x[k] <= nxt_sq_x[k];
      sq_y      <= nxt_sq_y;
    end
  end

  always_comb begin
    nxt_state     = state;
    nxt_dir       = dir;
    nxt_col       = col;
    nxt_row       = row;
    nxt_tcol      = tcol;
    nxt_trow      = trow;
    nxt_idx       = idx;
    nxt_blk       = blk;
    nxt_hard      = hard;
    nxt_game_over = game_over;

    case (state)
      S_IDLE: begin
        if (start) begin
          nxt_state = S_SPAWN;
          nxt_tcol  = COL_W'(SPAWN_COL);
          nxt_trow  = '0;
          nxt_idx   = '0;
          nxt_blk   = 1'b0;
          nxt_hard  = 1'b0;
        end
      end
      S_WAIT: begin
        nxt_idx = '0;
        nxt_blk = 1'b0;
        if (hd_req || tick_down) begin
          nxt_state = S_CHECK;
          nxt_dir   = D_DOWN;
          nxt_hard  = hd_req;
          nxt_tcol  = col;
          nxt_trow  = row + ROW_W'(1);
        end else if (move_left) begin
          nxt_state = S_CHECK;
          nxt_dir   = D_LEFT;
          nxt_tcol  = col - COL_W'(1);
          nxt_trow  = row;
        end else if (move_right) begin
          nxt_state = S_CHECK;
          nxt_dir   = D_RIGHT;
          nxt_tcol  = col + COL_W'(1);
          nxt_trow  = row;
        end
      end
      S_SPAWN, S_CHECK: begin
        if (idx != IDX_W'(3)) begin
          nxt_idx = idx + IDX_W'(1);
          nxt_blk = blk_acc;
        end else begin
          nxt_idx = '0;
          nxt_blk = 1'b0;
          if (!blk_acc) begin
            nxt_col = tcol;
            nxt_row = trow;
            // Hard drop keeps probing one row lower without revisiting WAIT.
            if (state == S_CHECK && hard) begin
              nxt_trow = trow + ROW_W'(1);
            end else begin
              nxt_state = S_WAIT;
              nxt_hard  = 1'b0;
            end
          end else if (state == S_SPAWN) begin
            nxt_game_over = 1'b1;
            nxt_state     = S_OVER;
          end else if (dir == D_DOWN) begin
            nxt_state = S_LAND;
            nxt_hard  = 1'b0;
          end else begin
            nxt_state = S_WAIT;
          end
        end
      end
      S_LAND: begin
        nxt_state = S_SPAWN;
        nxt_col   = COL_W'(SPAWN_COL);
        nxt_row   = '0;
        nxt_tcol  = COL_W'(SPAWN_COL);
        nxt_trow  = '0;
        nxt_idx   = '0;
        nxt_blk   = 1'b0;
      end
      S_OVER: begin
        nxt_state = S_OVER;
      end
      default: begin
        nxt_state = S_IDLE;
      end
    endcase

    // Registered outputs derived from the next-state values.
    nxt_qcol = '0;
    nxt_qrow = '0;
    if (nxt_state == S_SPAWN || nxt_state == S_CHECK) begin
      nxt_qcol = Q_W'(nxt_tcol + COL_W'(nxt_idx));
      nxt_qrow = Q_W'(nxt_trow);
    end
    nxt_at_bottom = (nxt_state == S_LAND);
    nxt_busy      = !(nxt_state == S_WAIT || nxt_state == S_IDLE);
    for (int k = 0; k < 4; k++) nxt_sq_x[k] = PIX_W'((32'(nxt_col) + 32'(k)) * CELL);
    nxt_sq_y = PIX_W'(32'(nxt_row) * CELL);
  end

endmodule

// File: tb/tb_piece_controller.sv
// Scoreboard bench for piece_controller: a reference board model answers queries and predicts each request's outcome.
module tb_piece_controller;

  logic       Clk, Reset, start, tick_down, move_left, move_right, query_occupied;
`ifdef PIECE_HARD_DROP_EN
  logic       hard_drop;
`endif
  logic [4:0] query_col, query_row;
  logic [9:0] square1x, square2x, square3x, square4x;
  logic [9:0] square1y, square2y, square3y, square4y;
  logic       at_bottom, game_over, busy;

  piece_controller dut (
    .Clk(Clk), .Reset(Reset), .start(start), .tick_down(tick_down),
    .move_left(move_left), .move_right(move_right),
`ifdef PIECE_HARD_DROP_EN
    .hard_drop(hard_drop),
`endif
    .query_occupied(query_occupied), .query_col(query_col), .query_row(query_row),
    .square1x(square1x), .square2x(square2x), .square3x(square3x), .square4x(square4x),
    .square1y(square1y), .square2y(square2y), .square3y(square3y), .square4y(square4y),
    .at_bottom(at_bottom), .game_over(game_over), .busy(busy)
  );

  typedef struct {
    int x1;
    int y;
    bit land;
    int land_x1;
    int land_y;
    bit over;
    bit was_over;
  } exp_t;

  exp_t sb[$];
  bit   occ [20][20];
  int   m_col, m_row;
  bit   m_over;
  int   n_checks = 0;
  int   n_fail   = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Out-of-range probes answer 0 so the DUT must flag them itself.
  always_comb begin
    query_occupied = 1'b0;
    if (query_col < 5'd20 && query_row < 5'd20) query_occupied = occ[query_row][query_col];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit blocked(input int c, input int r);
    for (int i = 0; i < 4; i++) begin
      if (c + i < 0 || c + i >= 20 || r >= 20) return 1'b1;
      if (occ[r][c + i]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_x1"}, 32'(square1x), 200);
    check_eq({tag, "_x2"}, 32'(square2x), 220);
    check_eq({tag, "_x3"}, 32'(square3x), 240);
    check_eq({tag, "_x4"}, 32'(square4x), 260);
    check_eq({tag, "_y"},  32'({square1y, square4y}), 0);
    check_eq({tag, "_at_bottom"}, 32'(at_bottom), 0);
    check_eq({tag, "_game_over"}, 32'(game_over), 0);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_query"}, 32'({query_col, query_row}), 0);
  endtask

  // kind: 0 down, 1 left, 2 right, 3 down+right together, 4 start
  task automatic do_req(input string tag, input int kind);
    exp_t e;
    int tc, tr, lat, nab, fin, lx, lx4, ly, ax, ay;
    bit done;
    e.land = 1'b0; e.land_x1 = 0; e.land_y = 0;
    e.was_over = m_over;
    if (!m_over) begin
      if (kind == 4) begin
        m_col = 10; m_row = 0;
        if (blocked(10, 0)) m_over = 1'b1;
      end else begin
        tc = m_col; tr = m_row;
        if (kind == 0 || kind == 3) tr = m_row + 1;
        else if (kind == 1) tc = m_col - 1;
        else tc = m_col + 1;
        if (!blocked(tc, tr)) begin
          m_col = tc; m_row = tr;
        end else if (tr != m_row) begin
          e.land = 1'b1; e.land_x1 = m_col * 20; e.land_y = m_row * 20;
          for (int i = 0; i < 4; i++) occ[m_row][m_col + i] = 1'b1;
          m_col = 10; m_row = 0;
          if (blocked(10, 0)) m_over = 1'b1;
        end
      end
    end
    e.x1 = m_col * 20; e.y = m_row * 20; e.over = m_over;
    sb.push_back(e);

    start      = (kind == 4);
    tick_down  = (kind == 0 || kind == 3);
    move_left  = (kind == 1);
    move_right = (kind == 2 || kind == 3);
    @(negedge Clk);
    start = 1'b0; tick_down = 1'b0; move_left = 1'b0; move_right = 1'b0;

    lat = -1; nab = 0; fin = -1; lx = -1; lx4 = -1; ly = -1; ax = -1; ay = -1; done = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (at_bottom) begin
        nab++;
        if (lat < 0) begin
          lat = c; lx = int'(square1x); lx4 = int'(square4x); ly = int'(square4y);
        end
      end else if (lat > 0 && c == lat + 1) begin
        ax = int'(square1x); ay = int'(square1y);
      end
      if (e.was_over ? (c == 6) : (!busy || game_over)) begin
        done = 1'b1; fin = c;
        break;
      end
      @(negedge Clk);
    end

    e = sb.pop_front();
    check_eq({tag, "_timeout"}, 32'(done), 1);
    check_eq({tag, "_x1"}, 32'(square1x), e.x1);
    check_eq({tag, "_x4"}, 32'(square4x), e.x1 + 60);
    check_eq({tag, "_y"}, 32'(square2y), e.y);
    check_eq({tag, "_game_over"}, 32'(game_over), 32'(e.over));
    check_eq({tag, "_at_bottom_cycles"}, nab, e.land ? 1 : 0);
    if (!e.was_over) check_eq({tag, "_latency"}, fin, e.land ? 10 : 5);
    if (e.land) begin
      check_eq({tag, "_land_latency"}, lat, 5);
      check_eq({tag, "_land_x1"}, lx, e.land_x1);
      check_eq({tag, "_land_x4"}, lx4, e.land_x1 + 60);
      check_eq({tag, "_land_y"}, ly, e.land_y);
      check_eq({tag, "_respawn_x"}, ax, 200);
      check_eq({tag, "_respawn_y"}, ay, 0);
    end
  endtask

  task automatic apply_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    m_col = 10; m_row = 0; m_over = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; start = 1'b0; tick_down = 1'b0; move_left = 1'b0; move_right = 1'b0;
`ifdef PIECE_HARD_DROP_EN
    hard_drop = 1'b0;
`endif
    for (int r = 0; r < 20; r++) for (int c = 0; c < 20; c++) occ[r][c] = 1'b0;

    apply_reset();
    check_reset_vals("reset");
    repeat (2) @(negedge Clk);
    check_eq("idle_busy", 32'(busy), 0);

    do_req("start", 4);
    for (int n = 0; n < 20; n++) begin
      do_req($sformatf("fall%0d", n), 0);
      repeat (3) @(negedge Clk);
    end

    for (int c = 0; c < 20; c++) occ[19][c] = 1'b1;
    for (int n = 0; n < 19; n++) begin
      do_req($sformatf("row19_%0d", n), 0);
      repeat (3) @(negedge Clk);
    end

    for (int n = 0; n < 11; n++) do_req($sformatf("left%0d", n), 1);
    do_req("down_vs_right", 3);
    for (int n = 0; n < 17; n++) do_req($sformatf("right%0d", n), 2);

    for (int c = 10; c < 14; c++) occ[0][c] = 1'b1;
    for (int n = 0; n < 25 && !m_over; n++) do_req($sformatf("to_over%0d", n), 0);
    check_eq("game_over_reached", 32'(m_over), 1);
    do_req("over_tick", 0);
    do_req("over_left", 1);

    // Landing pending in CHECK is cancelled by a reset.
    apply_reset();
    check_reset_vals("reset2");
    for (int r = 0; r < 20; r++) for (int c = 0; c < 20; c++) occ[r][c] = 1'b0;
    for (int c = 0; c < 20; c++) occ[1][c] = 1'b1;
    do_req("start2", 4);
    tick_down = 1'b1;
    @(negedge Clk);
    tick_down = 1'b0;
    repeat (2) @(negedge Clk);
    check_eq("mid_check_busy", 32'(busy), 1);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check_reset_vals("reset_in_check");
    begin
      int nab2 = 0;
      for (int c = 0; c < 6; c++) begin
        if (at_bottom) nab2++;
        @(negedge Clk);
      end
      check_eq("cancelled_at_bottom", nab2, 0);
      check_eq("post_reset_busy", 32'(busy), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1);
  end

endmodule

// File: doc/piece_controller.md
Name: piece_controller

Overview:
- Active-piece stage directly upstream of the gameboard.
- Owns the falling 4-square horizontal bar and applies gravity ticks and left/right requests.
- Checks each candidate position against board occupancy through a one-cell-per-cycle query port.
- Drives square1x..square4y (pixels) and a one-cycle at_bottom pulse; the gameboard latches the piece into the board on that pulse.

Parameters:
- CELL, 20, square edge in pixels
- BOARD_COLS, 20, playfield width in cells
- BOARD_ROWS, 20, playfield height in cells
- SPAWN_COL, 10, leftmost cell column of a new piece

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- start  in  1  begin a game (level, sampled in IDLE)
- tick_down  in  1  gravity/soft-drop request, 1-cycle pulse
- move_left  in  1  shift-left request, 1-cycle pulse
- move_right  in  1  shift-right request, 1-cycle pulse
- query_occupied  in  1  combinational board answer for query_col/query_row
- query_col  out  5  cell column being queried
- query_row  out  5  cell row being queried
- square1x..square4x  out  10 each  left-edge pixel x of squares 1..4
- square1y..square4y  out  10 each  top-edge pixel y of squares 1..4
- at_bottom  out  1  landing pulse, one cycle
- game_over  out  1  sticky; spawn blocked
- busy  out  1  high in any state except WAIT and IDLE

Behaviour:
- Internal state:
  - piece position (col, row) of square 1.
  - Square k sits at (col+k-1, row).
  - squarekx = (col+k-1)*CELL; squareky = row*CELL. 10-bit results, registered.
- Reset, synchronous:
  - state IDLE; col=SPAWN_COL; row=0.
  - Outputs: squares x=200,220,240,260, y=0; at_bottom=0; game_over=0; query_col/query_row=0.
- States: IDLE, SPAWN, WAIT, CHECK, LAND, OVER.
- IDLE:
  - start=1 -> SPAWN; the target is (SPAWN_COL, 0).
- WAIT:
  - Requests are sampled only here; requests in other states are dropped, not queued.
  - Simultaneous requests: tick_down wins, then move_left, then move_right.
  - The winning request sets the target: (col,row+1), (col-1,row) or (col+1,row). Next state is CHECK.
- CHECK / SPAWN:
  - 4 cycles, index i=0..3; query_col=target_col+i, query_row=target_row.
  - A cell counts as blocked if query_occupied=1, if target_col+i<0 or >=BOARD_COLS, or if target_row>=BOARD_ROWS.
  - Out-of-range cells are flagged without relying on query_occupied.
  - Blocked flag is accumulated across all 4 cycles; there is no early exit.
  - After i=3:
    - Free: col/row take the target and outputs update on the same edge. Next state WAIT.
    - Blocked left/right: position unchanged, next state WAIT.
    - Blocked down: next state LAND.
    - Blocked SPAWN: game_over=1, next state OVER.
- Latency: request sampled at edge E, query cycles E+1..E+4, new squares visible after edge E+4, WAIT again after E+4.
- LAND:
  - at_bottom=1 for exactly one cycle, with squares still at the landed position. The gameboard captures them then.
  - Next: col=SPAWN_COL, row=0, SPAWN.
- OVER:
  - Holds all outputs; only Reset exits.
- Reset mid-operation:
  - Reset in any state, including CHECK or LAND, returns to reset values next edge.
  - A pending at_bottom is cancelled.
- Left wall: a col-1 target underflows; that is detected as out-of-range, never as a wrap.

Optional Feature:
- Macro: PIECE_HARD_DROP_EN.
- When defined:
  - Adds input port hard_drop (1 bit), priority above tick_down in WAIT.
  - Runs repeated down checks: after each free 4-cycle check, row increments and a new check starts with no return to WAIT.
  - The first blocked check goes to LAND. busy stays high throughout.
- When undefined:
  - hard_drop port is absent; behaviour is identical otherwise.

Test Plan:
- Reset held 2 cycles -> squares (200,0),(220,0),(240,0),(260,0); at_bottom=0, game_over=0, busy=0, state IDLE.
- start, query_occupied=0, 20 tick_down pulses spaced 8 cycles:
  - 19 ticks move the piece; y reaches 380.
  - The 20th tick causes one at_bottom cycle with all y=380 and x=200..260.
  - Next cycle the piece is back at spawn.
- Occupancy model with row 19 full, tick_down repeated -> at_bottom with y=360, asserted exactly 5 cycles after the blocking tick sample.
- 11 move_left pulses from spawn:
  - First 10 reach x=0,20,40,60.
  - The 11th leaves the position unchanged, with no at_bottom and no wrap.
- tick_down and move_right in the same WAIT cycle -> only the down move is applied (row+1, col unchanged).
- Spawn cells (10..13,0) occupied after a landing -> game_over=1 sticky. Later requests are ignored until Reset, and Reset asserted during CHECK returns everything to reset values next edge.
